// File: rtl/avl_mem_pkg.sv
// Shared types and helpers for the configurable Avalon-MM slave memory model.
// Region decode is per byte so lanes of one word may land in different regions.
package avl_mem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef enum logic [1:0] {REG_DATA, REG_INSTR, REG_TOP, REG_NONE} region_t;

    typedef struct packed {
        region_t     region;
        logic [31:0] offset;
    } decode_t;

    localparam logic [31:0] DEF_DATA_BASE  = 32'h0000_0000;
    localparam logic [31:0] DEF_INSTR_BASE = 32'hBFC0_0000;

    // Taps 16,14,13,11 for a right-shifting Fibonacci register (bit 0 is tap 16).
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Unsigned (a - base) < size keeps the compare free of wrap artefacts.
    function automatic decode_t decode(input logic [31:0] a, input logic [31:0] data_base,
                                       input logic [31:0] instr_base, input logic [31:0] block_size);
        decode_t     r;
        logic [31:0] top_base;
        top_base = 32'hFFFF_FFFF - block_size + 32'd1;
        r.region = REG_NONE;
        r.offset = '0;
        if ((a - data_base) < block_size) begin
            r.region = REG_DATA;
            r.offset = a - data_base;
        end else if ((a - instr_base) < block_size) begin
            r.region = REG_INSTR;
            r.offset = a - instr_base;
        end else if ((a - top_base) < block_size) begin
            r.region = REG_TOP;
            r.offset = a - top_base;
        end
        return r;
    endfunction

endpackage

// File: rtl/avl_lfsr16.sv
// 16-bit Fibonacci LFSR used to jitter the wait-state count; steps only on request.
module avl_lfsr16
    import avl_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] value
);

    logic [15:0] lfsr_q;
    logic        fb;

    assign fb    = ^(lfsr_q & LFSR_TAPS);
    assign value = lfsr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= seed;
        end else if (step) begin
            lfsr_q <= {fb, lfsr_q[15:1]};
        end
    end

endmodule

// File: rtl/avl_slave_mem_cfg.sv
// Avalon-MM slave memory model: three byte-addressed regions, configurable and
// optionally randomised wait states, sticky error flag and transfer counter.
module avl_slave_mem_cfg
    import avl_mem_pkg::*;
#(
    parameter              INSTR_INIT_FILE = "",
    parameter              DATA_INIT_FILE  = "",
    parameter int          BLOCK_SIZE      = 8192,
    parameter logic [31:0] DATA_BASE       = DEF_DATA_BASE,
    parameter logic [31:0] INSTR_BASE      = DEF_INSTR_BASE,
    parameter int          READ_DELAY      = 4,
    parameter int          WRITE_DELAY     = 2,
    parameter int          RANDOM_DELAY    = 0,
    parameter int          MAX_RAND        = 7,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    parameter int          FATAL_ON_ERR    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    input  logic        read,
    input  logic        write,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic        error,
    output logic [31:0] xfer_count
);

    localparam int AW    = $clog2(BLOCK_SIZE);
    localparam int WORDS = BLOCK_SIZE / 4;

    // Word-organised storage; byte o of a region is word o>>2, lane o[1:0].
    logic [31:0] mem_data  [WORDS];
    logic [31:0] mem_instr [WORDS];
    logic [31:0] mem_top   [WORDS];

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        op_q, op_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] xfer_q, xfer_d;

    logic        lfsr_step;
    logic [15:0] lfsr_val;

    decode_t     dec;
    region_t     lane_reg [4];
    logic [AW-3:0] lane_wrd [4];
    logic [1:0]  lane_sel [4];
    logic [3:0]  lane_map;
    logic [31:0] rd_word;
    logic        off_unused;
    logic        misaligned;
    logic        unmapped;
    logic        do_write;
    logic        err_event;
    logic [31:0] err_addr;

    avl_lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .seed  (LFSR_SEED),
        .step  (lfsr_step),
        .value (lfsr_val)
    );

    // Per-lane decode of the latched address and read-side byte gather.
    always_comb begin
        rd_word    = '0;
        lane_map   = '0;
        off_unused = 1'b0;
        dec        = '0;
        for (int i = 0; i < 4; i++) begin
            dec         = decode(addr_q + 32'(i), DATA_BASE, INSTR_BASE, 32'(BLOCK_SIZE));
            lane_reg[i] = dec.region;
            lane_wrd[i] = dec.offset[AW-1:2];
            lane_sel[i] = dec.offset[1:0];
            off_unused  = off_unused ^ (^dec.offset[31:AW]);
            lane_map[i] = (dec.region != REG_NONE);
            if (be_q[i]) begin
                case (dec.region)
                    REG_DATA:  rd_word[8*i +: 8] = mem_data[lane_wrd[i]][8*lane_sel[i] +: 8];
                    REG_INSTR: rd_word[8*i +: 8] = mem_instr[lane_wrd[i]][8*lane_sel[i] +: 8];
                    REG_TOP:   rd_word[8*i +: 8] = mem_top[lane_wrd[i]][8*lane_sel[i] +: 8];
                    default:   rd_word[8*i +: 8] = 8'h00;
                endcase
            end
        end
    end

    assign misaligned = (addr_q[1:0] != 2'b00);
    assign unmapped   = |(be_q & ~lane_map);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        op_d        = op_q;
        rdata_d     = rdata_q;
        xfer_d      = xfer_q;
        lfsr_step   = 1'b0;
        do_write    = 1'b0;
        err_event   = 1'b0;
        err_addr    = addr_q;
        waitrequest = 1'b0;
        case (state_q)
            IDLE: begin
                waitrequest = read ^ write;
                if (read && write) begin
                    err_event = 1'b1;
                    err_addr  = address;
                end else if (read || write) begin
                    addr_d    = address;
                    be_d      = byteenable;
                    wdata_d   = writedata;
                    op_d      = write;
                    cnt_d     = (write ? 32'(WRITE_DELAY) : 32'(READ_DELAY))
                              + ((RANDOM_DELAY != 0) ? (32'(lfsr_val) & 32'(MAX_RAND)) : 32'd0);
                    lfsr_step = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                waitrequest = 1'b1;
                if (cnt_q != 32'd0) begin
                    cnt_d = cnt_q - 32'd1;
                end else begin
                    // Misaligned accesses complete but never touch memory.
                    rdata_d   = (!op_q && !misaligned) ? rd_word : 32'd0;
                    do_write  = op_q && !misaligned;
                    err_event = misaligned || unmapped;
                    state_d   = DONE;
                end
            end
            DONE: begin
                xfer_d  = xfer_q + 32'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        err_d = err_q | err_event;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            op_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            xfer_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            op_q    <= op_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            xfer_q  <= xfer_d;
        end
    end

    // Memory is deliberately outside reset; do_write is gated by the reset state.
    always @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    case (lane_reg[i])
                        REG_DATA:  mem_data[lane_wrd[i]][8*lane_sel[i] +: 8]  <= wdata_q[8*i +: 8];
                        REG_INSTR: mem_instr[lane_wrd[i]][8*lane_sel[i] +: 8] <= wdata_q[8*i +: 8];
                        REG_TOP:   mem_top[lane_wrd[i]][8*lane_sel[i] +: 8]   <= wdata_q[8*i +: 8];
                        default: ;
                    endcase
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && (FATAL_ON_ERR != 0) && err_event) begin
            $fatal(2, "avl_slave_mem_cfg: protocol error at address %h", err_addr);
        end
    end

    assign readdata   = rdata_q;
    assign error      = err_q;
    assign xfer_count = xfer_q;

endmodule

// File: tb/tb_avl_slave_mem_cfg.sv
// Scoreboard bench: the driver predicts each response (data, stall length from a
// reference LFSR, sticky error, transfer count) and a monitor checks completions.
module tb_avl_slave_mem_cfg;

    localparam int          RD_DLY = 4;
    localparam int          WR_DLY = 0;
    localparam int          MAXR   = 7;
    localparam logic [15:0] SEED   = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address, writedata, readdata, xfer_count;
    logic [3:0]  byteenable;
    logic        read, write, waitrequest, error;

    always #5 clk = ~clk;

    avl_slave_mem_cfg #(
        .BLOCK_SIZE   (8192),
        .READ_DELAY   (RD_DLY),
        .WRITE_DELAY  (WR_DLY),
        .RANDOM_DELAY (1),
        .MAX_RAND     (MAXR),
        .LFSR_SEED    (SEED),
        .FATAL_ON_ERR (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .byteenable  (byteenable),
        .writedata   (writedata),
        .read        (read),
        .write       (write),
        .readdata    (readdata),
        .waitrequest (waitrequest),
        .error       (error),
        .xfer_count  (xfer_count)
    );

    typedef struct {
        string       name;
        logic        chk_rdata;
        logic [31:0] rdata;
        int          stall;
        logic        err;
        logic [31:0] xfer;
    } exp_t;

    exp_t        sbq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] lfsr_m;
    logic        err_m;
    logic [31:0] xfer_m;
    logic [31:0] pat [8];

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic b;
        b = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {b, l[15:1]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic reset_checks(input string name);
        check({name, "_waitreq"}, {31'b0, waitrequest}, 32'd0);
        check({name, "_rdata"},   readdata,             32'd0);
        check({name, "_error"},   {31'b0, error},       32'd0);
        check({name, "_xfer"},    xfer_count,           32'd0);
    endtask

    // bad: hand-derived "this access raises error"; chk/exp_rd: expected readdata.
    task automatic do_op(input string name, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd, input logic bad,
                         input logic chk, input logic [31:0] exp_rd);
        exp_t e;
        bit   done;
        e.name      = name;
        e.chk_rdata = chk && rd && !wr;
        e.rdata     = exp_rd;
        if (rd && wr) begin
            e.stall = 0;
            err_m   = 1'b1;
        end else begin
            e.stall = (wr ? WR_DLY : RD_DLY) + int'(lfsr_m & 16'(MAXR)) + 2;
            lfsr_m  = lfsr_next(lfsr_m);
            if (bad) err_m = 1'b1;
            xfer_m++;
        end
        e.err  = err_m;
        e.xfer = xfer_m;
        sbq.push_back(e);
        address    = a;
        byteenable = be;
        writedata  = wd;
        read       = rd;
        write      = wr;
        done       = 1'b0;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (!waitrequest) done = 1'b1;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: waitrequest still %b after 64 cycles, expected 0", name, waitrequest);
        end
        @(posedge clk);
        #1;
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic pulse_reset(input logic abort_wr);
        if (abort_wr) begin
            address    = 32'h20;
            writedata  = 32'hDEADBEEF;
            byteenable = 4'hF;
            write      = 1'b1;
            @(posedge clk);
            #2;
        end
        rst   = 1'b1;
        write = 1'b0;
        read  = 1'b0;
        #1;
        reset_checks(abort_wr ? "rst_abort" : "rst_idle");
        lfsr_m = SEED;
        err_m  = 1'b0;
        xfer_m = 32'd0;
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: counts stall cycles and checks every completed handshake.
    int          mstall;
    logic [31:0] mrdata;
    exp_t        me;
    initial begin
        mstall = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mstall = 0;
            end else if (read || write) begin
                if (waitrequest) begin
                    mstall++;
                end else begin
                    mrdata = readdata;
                    @(posedge clk);
                    #1;
                    if (sbq.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_response: readdata %h, expected no response", mrdata);
                    end else begin
                        me = sbq.pop_front();
                        check({me.name, "_stall"}, 32'(mstall), 32'(me.stall));
                        if (me.chk_rdata) check({me.name, "_rdata"}, mrdata, me.rdata);
                        check({me.name, "_error"}, {31'b0, error}, {31'b0, me.err});
                        check({me.name, "_xfer"},  xfer_count, me.xfer);
                    end
                    mstall = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; read = 1'b0; write = 1'b0;
        address = '0; byteenable = '0; writedata = '0;
        lfsr_m = SEED; err_m = 1'b0; xfer_m = 32'd0;
        for (int k = 0; k < 8; k++) pat[k] = 32'hA5A5_0000 | (32'(k) * 32'h0000_1111);
        repeat (2) @(negedge clk);
        reset_checks("reset");
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Instruction word preload and readback, sub-word lanes, region boundaries.
        do_op("wr_instr0", 0, 1, 32'hBFC00000, 4'hF, 32'h3C01BFC0, 0, 0, 32'h0);
        do_op("rd_instr0", 1, 0, 32'hBFC00000, 4'hF, 32'h0,        0, 1, 32'h3C01BFC0);
        do_op("wr_clr10",  0, 1, 32'h00000010, 4'hF, 32'h00000000, 0, 0, 32'h0);
        do_op("wr_be0101", 0, 1, 32'h00000010, 4'h5, 32'hAABBCCDD, 0, 0, 32'h0);
        do_op("rd_be_all", 1, 0, 32'h00000010, 4'hF, 32'h0,        0, 1, 32'h00BB00DD);
        do_op("rd_be1100", 1, 0, 32'h00000010, 4'hC, 32'h0,        0, 1, 32'h00BB0000);
        do_op("wr_top",    0, 1, 32'hFFFFFFFC, 4'hF, 32'hCAFEF00D, 0, 0, 32'h0);
        do_op("rd_top",    1, 0, 32'hFFFFFFFC, 4'hF, 32'h0,        0, 1, 32'hCAFEF00D);
        do_op("wr_dlast",  0, 1, 32'h00001FFC, 4'hF, 32'h13579BDF, 0, 0, 32'h0);
        do_op("rd_dlast",  1, 0, 32'h00001FFC, 4'hF, 32'h0,        0, 1, 32'h13579BDF);
        do_op("wr_ilast",  0, 1, 32'hBFC01FFC, 4'hF, 32'h2468ACE0, 0, 0, 32'h0);
        do_op("rd_ilast",  1, 0, 32'hBFC01FFC, 4'hF, 32'h0,        0, 1, 32'h2468ACE0);

        // Misaligned accesses: error goes sticky, memory is untouched.
        do_op("rd_misal",  1, 0, 32'h00000003, 4'hF, 32'h0,        1, 1, 32'h0);
        do_op("rd_after",  1, 0, 32'h00000010, 4'hF, 32'h0,        0, 1, 32'h00BB00DD);
        do_op("wr_misal",  0, 1, 32'h00000012, 4'hF, 32'hFFFFFFFF, 1, 0, 32'h0);
        do_op("rd_unchg",  1, 0, 32'h00000010, 4'hF, 32'h0,        0, 1, 32'h00BB00DD);
        do_op("rd_past_d", 1, 0, 32'h00002000, 4'hF, 32'h0,        1, 1, 32'h0);
        do_op("rd_below_t",1, 0, 32'hFFFFDFFC, 4'hF, 32'h0,        1, 1, 32'h0);

        // Reset during a write's wait states must abort it.
        do_op("wr_20",     0, 1, 32'h00000020, 4'hF, 32'h11223344, 0, 0, 32'h0);
        do_op("rd_20",     1, 0, 32'h00000020, 4'hF, 32'h0,        0, 1, 32'h11223344);
        pulse_reset(1'b1);
        do_op("rd_20_rst", 1, 0, 32'h00000020, 4'hF, 32'h0,        0, 1, 32'h11223344);

        // read and write together: immediate error, nothing counted.
        do_op("rd_wr",     1, 1, 32'h00000020, 4'hF, 32'h55555555, 1, 0, 32'h0);
        do_op("rd_20_err", 1, 0, 32'h00000020, 4'hF, 32'h0,        0, 1, 32'h11223344);
        pulse_reset(1'b0);
        do_op("rd_unmap",  1, 0, 32'h40000000, 4'hF, 32'h0,        1, 1, 32'h0);
        pulse_reset(1'b0);

        // Back-to-back reads with pseudo-random stalls.
        for (int k = 0; k < 8; k++)
            do_op("wr_pat", 0, 1, 32'h100 + 32'(4 * k), 4'hF, pat[k], 0, 0, 32'h0);
        for (int i = 0; i < 100; i++)
            do_op("rnd_rd", 1, 0, 32'h100 + 32'(4 * (i % 8)), 4'hF, 32'h0, 0, 1, pat[i % 8]);

        repeat (4) @(posedge clk);
        #1;
        check("sb_empty",   32'(sbq.size()), 32'd0);
        check("xfer_final", xfer_count,      xfer_m);
        check("err_final",  {31'b0, error},  32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
